dmem_arbiter: RTL

//   Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (loader/debug).

---
 rtl/dmem_arbiter_if.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and DMEM bus bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              done0;
   logic              done1;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   logic [ADDR_W-1:0] DMEM_address;
   logic [DATA_W-1:0] DMEM_data_in;
   logic              DMEM_mem_write;
   logic              DMEM_mem_read;
   logic [DATA_W-1:0] DMEM_data_out;

   modport slave (
      input  req0,
      input  req1,
      input  we0,
      input  we1,
      input  addr0,
      input  addr1,
      input  wdata0,
      input  wdata1,
      output done0,
      output done1,
      output rdata,
      output busy,
      output DMEM_address,
      output DMEM_data_in,
      output DMEM_mem_write,
      output DMEM_mem_read,
      input  DMEM_data_out
   );

   modport master (
      output req0,
      output req1,
      output we0,
      output we1,
      output addr0,
      output addr1,
      output wdata0,
      output wdata1,
      input  done0,
      input  done1,
      input  rdata,
      input  busy,
      input  DMEM_address,
      input  DMEM_data_in,
      input  DMEM_mem_write,
      input  DMEM_mem_read,
      output DMEM_data_out
   );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one DMEM port between two requesters.
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef DMEM_ARB_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1,
   output logic [CNT_W-1:0]  conflict_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic              last_gnt;
   logic              win;
   logic              grant;
   logic              any_req;
   logic              in_idle;
   logic              in_acc;
   logic              in_resp;

   logic              cmd_id;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] rdata_q;

   assign any_req = bus.req0 | bus.req1;
   assign in_idle = (state == ST_IDLE);
   assign in_acc  = (state == ST_ACCESS);
   assign in_resp = (state == ST_RESP);

   // Tie goes to the port that did not win last; otherwise the lone requester.
   always_comb begin
      win = bus.req1;
      if (bus.req0 && bus.req1) begin
         win = ~last_gnt;
      end
   end

   // Next-state: idle -> access -> resp -> idle, one access in flight.
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (any_req) begin
               grant    = 1'b1;
               state_nx = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_nx = ST_RESP;
         end
         ST_RESP: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Latch the winner's command; it also drives the DMEM address/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt  <= 1'b1;
         cmd_id    <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (grant) begin
         last_gnt  <= win;
         cmd_id    <= win;
         cmd_we    <= win ? bus.we1    : bus.we0;
         cmd_addr  <= win ? bus.addr1  : bus.addr0;
         cmd_wdata <= win ? bus.wdata1 : bus.wdata0;
      end
   end

   // Capture read data at the end of the access cycle; writes leave it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (in_acc && !cmd_we) begin
         rdata_q <= bus.DMEM_data_out;
      end
   end

   // Strobes are gated by reset so an aborted write never commits.
   assign bus.DMEM_address   = cmd_addr;
   assign bus.DMEM_data_in   = cmd_wdata;
   assign bus.DMEM_mem_write = in_acc & cmd_we & ~reset;
   assign bus.DMEM_mem_read  = in_acc & ~cmd_we & ~reset;

   assign bus.done0 = in_resp & ~cmd_id;
   assign bus.done1 = in_resp & cmd_id;
   assign bus.rdata = rdata_q;
   assign bus.busy  = in_acc | in_resp;

`ifdef DMEM_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic tie;
   assign tie = in_idle & bus.req0 & bus.req1;

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_cnt0     <= '0;
         gnt_cnt1     <= '0;
         conflict_cnt <= '0;
      end else begin
         if (grant && !win && (gnt_cnt0 != '1)) begin
            gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
         end
         if (grant && win && (gnt_cnt1 != '1)) begin
            gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
         end
         if (tie && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_ONE;
         end
      end
   end
`else
   logic unused_idle;
   assign unused_idle = in_idle;
`endif

endmodule
